// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: variant codes, rate lookup, padding bytes,
// lane placement and the 1600-bit Keccak state type.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_variant_e;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_OUT  = 2'd1,
    ST_PAD  = 2'd2
  } absorb_state_e;

  typedef logic [4:0][4:0][63:0] keccak_state_t;

  localparam int STATE_BYTES = 200;
  localparam int STATE_LANES = 25;

  localparam logic [7:0] DOMAIN_PAD = 8'h06;
  localparam logic [7:0] FINAL_PAD  = 8'h80;

  // Rate in bytes: 1600 bits minus twice the digest length.
  function automatic logic [7:0] rateBytes(input sha3_variant_e variant);
    case (variant)
      SHA3_224: return 8'd144;
      SHA3_256: return 8'd136;
      SHA3_384: return 8'd104;
      default:  return 8'd72;
    endcase
  endfunction

  // Flat lane L lives at state[L % 5][L / 5].
  function automatic logic [2:0] laneX(input int lane);
    return 3'(lane % 5);
  endfunction

  function automatic logic [2:0] laneY(input int lane);
    return 3'(lane / 5);
  endfunction

endpackage

// File: rtl/sha3_pad_gen.sv
// Byte-enable and padding-byte masks for the 200-byte absorb buffer.
// The write window is [base, base+count); padding places the domain byte
// right after the last message byte and the final bit in the last rate byte,
// the two OR-ing together into 0x86 when they coincide.
module sha3_pad_gen
  import sha3_pkg::*;
(
  input  logic [7:0]                   i_base,
  input  logic [7:0]                   i_count,
  input  logic [7:0]                   i_rate,
  input  logic                         i_write,
  input  logic                         i_pad,
  output logic [STATE_BYTES-1:0]       o_byteEn,
  output logic [STATE_BYTES-1:0][7:0]  o_padBytes
);

  logic [7:0] w_end;
  logic [7:0] w_finalPos;

  assign w_end      = i_base + i_count;
  assign w_finalPos = i_rate - 8'd1;

  // Per-byte decode of the write window and the two padding positions.
  always_comb begin
    o_byteEn   = '0;
    o_padBytes = '0;
    for (int j = 0; j < STATE_BYTES; j++) begin
      o_byteEn[j] = i_write && (8'(j) >= i_base) && (8'(j) < w_end);
      if (i_pad && (8'(j) == w_end)) begin
        o_padBytes[j] = o_padBytes[j] | DOMAIN_PAD;
      end
      if (i_pad && (8'(j) == w_finalPos)) begin
        o_padBytes[j] = o_padBytes[j] | FINAL_PAD;
      end
    end
  end

endmodule

// File: rtl/sha3_absorb_pad.sv
// AXI-Stream front end of the SHA-3 core: packs message words into a
// rate-sized block, applies SHA-3 padding and offers each 1600-bit block
// to the permutation with a valid/ready handshake. Single buffer, so
// filling and offering never overlap.
module sha3_absorb_pad
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic [KEEP_W-1:0]     S_TKEEP,
  input  logic [1:0]            S_TUSER,
  input  logic                  S_TLAST,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  output keccak_state_t         Block,
  output logic                  Block_valid,
  input  logic                  Block_ready,
  output logic                  Block_first,
  output logic                  Block_last,
  output logic [1:0]            Block_user
);

  absorb_state_e r_state;
  absorb_state_e w_nextState;

  logic [STATE_BYTES-1:0][7:0] r_buf;
  logic [7:0]                  r_n;
  logic                        r_first;
  logic                        r_last;
  logic                        r_padPending;
  logic                        r_inMsg;
  logic [1:0]                  r_user;

  logic                        w_accept;
  logic                        w_handshake;
  logic [1:0]                  w_rateVariant;
  logic [7:0]                  w_rate;
  logic [7:0]                  w_keepCount;
  logic [7:0]                  w_nNext;
  logic                        w_padNow;
  logic [7:0]                  w_genBase;
  logic [7:0]                  w_genCount;
  logic [STATE_BYTES-1:0]      w_byteEn;
  logic [STATE_BYTES-1:0][7:0] w_padBytes;
  logic [STATE_BYTES-1:0][7:0] w_mergedBuf;

  assign S_TREADY    = (r_state == ST_FILL);
  assign Block_valid = (r_state == ST_OUT);
  assign Block_first = (r_state == ST_OUT) && r_first;
  assign Block_last  = r_last;
  assign Block_user  = r_user;

  assign w_accept    = S_TVALID && (r_state == ST_FILL);
  assign w_handshake = (r_state == ST_OUT) && Block_ready;

  // The first beat of a message supplies the variant; afterwards the latch rules.
  assign w_rateVariant = ((r_state == ST_FILL) && !r_inMsg) ? S_TUSER : r_user;
  assign w_rate        = rateBytes(sha3_variant_e'(w_rateVariant));
  assign w_nNext       = r_n + w_keepCount;

  // Inline padding on a short last beat, or a pad-only block in PAD.
  assign w_padNow   = (w_accept && S_TLAST && (w_nNext < w_rate)) || (r_state == ST_PAD);
  assign w_genBase  = (r_state == ST_PAD) ? 8'd0 : r_n;
  assign w_genCount = (r_state == ST_PAD) ? 8'd0 : w_keepCount;

  // Count kept bytes; masks are contiguous-low so this is the byte length.
  always_comb begin
    w_keepCount = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      w_keepCount = w_keepCount + 8'(S_TKEEP[k]);
    end
  end

  sha3_pad_gen u_padGen (
    .i_base     (w_genBase),
    .i_count    (w_genCount),
    .i_rate     (w_rate),
    .i_write    (w_accept),
    .i_pad      (w_padNow),
    .o_byteEn   (w_byteEn),
    .o_padBytes (w_padBytes)
  );

  // Beats always start on a word boundary, so buffer byte j takes word byte j % KEEP_W.
  always_comb begin
    w_mergedBuf = r_buf;
    for (int j = 0; j < STATE_BYTES; j++) begin
      if (w_byteEn[j]) begin
        w_mergedBuf[j] = S_TDATA[8*(j % KEEP_W) +: 8];
      end
      w_mergedBuf[j] = w_mergedBuf[j] | w_padBytes[j];
    end
  end

  // Flat buffer lanes laid out onto the [x][y] state grid.
  always_comb begin
    Block = '0;
    for (int l = 0; l < STATE_LANES; l++) begin
      Block[laneX(l)][laneY(l)] = r_buf[8*l +: 8];
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state: fill until a block is complete, offer it, optionally pad.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_accept && (S_TLAST || (w_nNext == w_rate))) begin
          w_nextState = ST_OUT;
        end
      end
      ST_OUT: begin
        if (Block_ready) begin
          w_nextState = r_padPending ? ST_PAD : ST_FILL;
        end
      end
      ST_PAD:  w_nextState = ST_OUT;
      default: w_nextState = ST_FILL;
    endcase
  end

  // Buffer, byte count and message flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_buf        <= '0;
      r_n          <= '0;
      r_first      <= 1'b1;
      r_last       <= 1'b0;
      r_padPending <= 1'b0;
      r_inMsg      <= 1'b0;
      r_user       <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_buf   <= w_mergedBuf;
            r_n     <= w_nNext;
            r_inMsg <= !S_TLAST;
            if (!r_inMsg) begin
              r_user <= S_TUSER;
            end
            if (S_TLAST) begin
              if (w_nNext < w_rate) begin
                r_last <= 1'b1;
              end else begin
                r_padPending <= 1'b1;
              end
            end
          end
        end
        ST_OUT: begin
          if (w_handshake) begin
            r_buf   <= '0;
            r_n     <= '0;
            r_first <= !r_padPending && r_last;
            r_last  <= 1'b0;
          end
        end
        ST_PAD: begin
          r_buf        <= w_mergedBuf;
          r_last       <= 1'b1;
          r_padPending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// Directed bench for sha3_absorb_pad with hand-computed padded blocks.
module tb_sha3_absorb_pad;
  import sha3_pkg::*;

  localparam int DW = 16;
  localparam int KW = DW / 8;
  localparam logic [63:0] AA_LANE = 64'hAAAAAAAAAAAAAAAA;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [DW-1:0] S_TDATA;
  logic [KW-1:0] S_TKEEP;
  logic [1:0]    S_TUSER;
  logic          S_TLAST;
  logic          S_TVALID;
  logic          S_TREADY;
  keccak_state_t Block;
  logic          Block_valid;
  logic          Block_ready;
  logic          Block_first;
  logic          Block_last;
  logic [1:0]    Block_user;

  int checks = 0;
  int failures = 0;
  int acceptCount = 0;
  int acceptBefore;
  keccak_state_t expBlock;

  sha3_absorb_pad #(.DATA_WIDTH(DW), .KEEP_W(KW)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .S_TDATA     (S_TDATA),
    .S_TKEEP     (S_TKEEP),
    .S_TUSER     (S_TUSER),
    .S_TLAST     (S_TLAST),
    .S_TVALID    (S_TVALID),
    .S_TREADY    (S_TREADY),
    .Block       (Block),
    .Block_valid (Block_valid),
    .Block_ready (Block_ready),
    .Block_first (Block_first),
    .Block_last  (Block_last),
    .Block_user  (Block_user)
  );

  always #5 ACLK = ~ACLK;

  // Count every beat the DUT actually takes.
  always @(posedge ACLK) begin
    if (S_TVALID && S_TREADY) acceptCount++;
  end

  function automatic keccak_state_t setLane(input keccak_state_t s, input int lane,
                                            input logic [63:0] v);
    keccak_state_t r;
    r = s;
    r[lane % 5][lane / 5] = v;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBlock(input string tag, input keccak_state_t expected);
    int bx;
    int by;
    bx = 0;
    by = 0;
    checks++;
    assert (Block === expected) else begin
      failures++;
      for (int l = STATE_LANES - 1; l >= 0; l--) begin
        if (Block[l % 5][l / 5] !== expected[l % 5][l / 5]) begin
          bx = l % 5;
          by = l / 5;
        end
      end
      $error("[TB] FAIL %s lane[%0d][%0d] observed=0x%0h expected=0x%0h", tag, bx, by,
             Block[bx][by], expected[bx][by]);
    end
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic applyStimulus(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                               input logic [1:0] user, input logic last);
    int waitCycles;
    waitCycles = 0;
    @(negedge ACLK);
    while (!S_TREADY && waitCycles < 300) begin
      @(negedge ACLK);
      waitCycles++;
    end
    if (!S_TREADY) begin
      checkOutput("tready_timeout", 64'(S_TREADY), 64'd1);
    end else begin
      S_TDATA  = data;
      S_TKEEP  = keep;
      S_TUSER  = user;
      S_TLAST  = last;
      S_TVALID = 1'b1;
      @(posedge ACLK);
      #1;
      S_TVALID = 1'b0;
      S_TLAST  = 1'b0;
    end
  endtask

  task automatic waitBlock(input string tag);
    int waitCycles;
    waitCycles = 0;
    while (!Block_valid && waitCycles < 300) begin
      @(negedge ACLK);
      waitCycles++;
    end
    checkOutput(tag, 64'(Block_valid), 64'd1);
  endtask

  task automatic takeBlock();
    @(negedge ACLK);
    Block_ready = 1'b1;
    @(posedge ACLK);
    #1;
    Block_ready = 1'b0;
  endtask

  // Message of 'total' bytes of 0xAA, last beat carrying TLAST.
  task automatic sendFill(input int total, input logic [1:0] user);
    int full;
    full = total / 2;
    for (int i = 0; i < full; i++) begin
      applyStimulus(16'hAAAA, 2'b11, user, (i == full - 1) && (total % 2 == 0));
    end
    if (total % 2 != 0) begin
      applyStimulus(16'h00AA, 2'b01, user, 1'b1);
    end
  endtask

  initial begin
    ARESETN     = 1'b0;
    S_TDATA     = '0;
    S_TKEEP     = '0;
    S_TUSER     = '0;
    S_TLAST     = 1'b0;
    S_TVALID    = 1'b0;
    Block_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Reset state.
    checkOutput("rst_valid", 64'(Block_valid), 64'd0);
    checkOutput("rst_tready", 64'(S_TREADY), 64'd1);
    checkOutput("rst_first", 64'(Block_first), 64'd0);
    checkOutput("rst_last", 64'(Block_last), 64'd0);
    checkOutput("rst_user", 64'(Block_user), 64'd0);
    checkBlock("rst_block", '0);

    // Empty SHA3-256 message: R=136, final bit in byte 135 = lane 16 -> [1][3].
    applyStimulus(16'h0000, 2'b00, 2'd1, 1'b1);
    checkOutput("empty_latency", 64'(Block_valid), 64'd1);
    expBlock = '0;
    expBlock = setLane(expBlock, 0, 64'h06);
    expBlock = setLane(expBlock, 16, 64'h8000000000000000);
    checkBlock("empty_block", expBlock);
    checkOutput("empty_lane00", Block[0][0], 64'h06);
    checkOutput("empty_lane13", Block[1][3], 64'h8000000000000000);
    checkOutput("empty_first", 64'(Block_first), 64'd1);
    checkOutput("empty_last", 64'(Block_last), 64'd1);
    checkOutput("empty_user", 64'(Block_user), 64'd1);
    takeBlock();
    checkOutput("empty_after_valid", 64'(Block_valid), 64'd0);
    checkBlock("empty_after_clear", '0);

    // "abc"; second beat carries TUSER=3, which must be ignored.
    applyStimulus(16'h6261, 2'b11, 2'd1, 1'b0);
    applyStimulus(16'h0063, 2'b01, 2'd3, 1'b1);
    checkOutput("abc_latency", 64'(Block_valid), 64'd1);
    expBlock = '0;
    expBlock = setLane(expBlock, 0, 64'h0000000006636261);
    expBlock = setLane(expBlock, 16, 64'h8000000000000000);
    checkBlock("abc_block", expBlock);
    checkOutput("abc_lane00", Block[0][0], 64'h0000000006636261);
    checkOutput("abc_user", 64'(Block_user), 64'd1);
    checkOutput("abc_first", 64'(Block_first), 64'd1);
    checkOutput("abc_last", 64'(Block_last), 64'd1);
    takeBlock();

    // 135 bytes, SHA3-256: domain and final bit collide in byte 135 -> 0x86.
    sendFill(135, 2'd1);
    waitBlock("r1_valid");
    expBlock = '0;
    for (int l = 0; l < 16; l++) expBlock = setLane(expBlock, l, AA_LANE);
    expBlock = setLane(expBlock, 16, 64'h86AAAAAAAAAAAAAA);
    checkBlock("r1_block", expBlock);
    checkOutput("r1_lane13", Block[1][3], 64'h86AAAAAAAAAAAAAA);
    checkOutput("r1_first", 64'(Block_first), 64'd1);
    checkOutput("r1_last", 64'(Block_last), 64'd1);
    takeBlock();

    // 72 bytes, SHA3-512: exactly one full block, then a pad-only block.
    sendFill(72, 2'd3);
    waitBlock("full_valid");
    expBlock = '0;
    for (int l = 0; l < 9; l++) expBlock = setLane(expBlock, l, AA_LANE);
    checkBlock("full_block", expBlock);
    checkOutput("full_first", 64'(Block_first), 64'd1);
    checkOutput("full_last", 64'(Block_last), 64'd0);
    checkOutput("full_user", 64'(Block_user), 64'd3);

    // Backpressure with a beat waiting on the input side.
    acceptBefore = acceptCount;
    @(negedge ACLK);
    S_TDATA  = 16'h5555;
    S_TKEEP  = 2'b11;
    S_TUSER  = 2'd0;
    S_TVALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      checkOutput("bp_tready", 64'(S_TREADY), 64'd0);
      checkOutput("bp_valid", 64'(Block_valid), 64'd1);
      checkOutput("bp_first", 64'(Block_first), 64'd1);
      checkOutput("bp_last", 64'(Block_last), 64'd0);
      checkBlock("bp_block", expBlock);
    end
    S_TVALID = 1'b0;
    checkOutput("bp_accepts", 64'(acceptCount), 64'(acceptBefore));

    takeBlock();
    checkOutput("pad_gap_valid", 64'(Block_valid), 64'd0);
    @(posedge ACLK);
    #1;
    checkOutput("pad_valid", 64'(Block_valid), 64'd1);
    expBlock = '0;
    expBlock = setLane(expBlock, 0, 64'h06);
    expBlock = setLane(expBlock, 8, 64'h8000000000000000);
    checkBlock("pad_block", expBlock);
    checkOutput("pad_lane31", Block[3][1], 64'h8000000000000000);
    checkOutput("pad_first", 64'(Block_first), 64'd0);
    checkOutput("pad_last", 64'(Block_last), 64'd1);
    checkOutput("pad_user", 64'(Block_user), 64'd3);
    takeBlock();

    // Reset mid-message discards the partial block.
    for (int i = 0; i < 20; i++) applyStimulus(16'hAAAA, 2'b11, 2'd0, 1'b0);
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    checkBlock("mid_rst_block", '0);
    checkOutput("mid_rst_valid", 64'(Block_valid), 64'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;

    // Empty SHA3-384 message: R=104, byte 103 is lane 12 -> [2][2].
    applyStimulus(16'h0000, 2'b00, 2'd2, 1'b1);
    waitBlock("e384_valid");
    expBlock = '0;
    expBlock = setLane(expBlock, 0, 64'h06);
    expBlock = setLane(expBlock, 12, 64'h8000000000000000);
    checkBlock("e384_block", expBlock);
    checkOutput("e384_lane22", Block[2][2], 64'h8000000000000000);
    checkOutput("e384_user", 64'(Block_user), 64'd2);
    checkOutput("e384_first", 64'(Block_first), 64'd1);
    takeBlock();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
